// File: rtl/mem_arbiter_if.sv
// Requester and RAM signal bundle for mem_arbiter.
// slave = the arbiter; master = the requesters plus the RAM macro around it.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic [2:0]          req;
   logic [2:0]          we;
   logic [3*ADDR_W-1:0] addr;
   logic [3*DATA_W-1:0] wdata;
   logic [2:0]          gnt;
   logic [2:0]          rvalid;
   logic [DATA_W-1:0]   rdata;
   logic                ram_en;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   modport master (
      output req, we, addr, wdata, ram_rdata,
      input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  req, we, addr, wdata, ram_rdata,
      output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of a single-port synchronous RAM,
// with a tag pipeline that steers each read result back to its issuer.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned READ_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int unsigned NPORT = 3;
   localparam int unsigned ID_W  = 2;

   logic [NPORT-1:0]               gnt_q, gnt_d;
   logic [ID_W-1:0]                ptr_q, ptr_d;
   logic                           ram_en_q, ram_en_d;
   logic                           ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]              ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]              ram_wdata_q, ram_wdata_d;
   logic [ID_W-1:0]                cmd_id_q, cmd_id_d;
   logic [READ_LAT-1:0]            tag_vld_q, tag_vld_d;
   logic [READ_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
   logic [NPORT-1:0]               rvalid_q, rvalid_d;
   logic [DATA_W-1:0]              rdata_q, rdata_d;

   logic [NPORT-1:0] elig;
   logic [ID_W-1:0]  ptr_eff, ord0, ord1, ord2, win;
   logic             found;

   function automatic logic [ID_W-1:0] inc3(input logic [ID_W-1:0] p);
      return (p >= ID_W'(2)) ? ID_W'(0) : ID_W'(p + ID_W'(1));
   endfunction

   // Round-robin pick; a port whose grant is showing sits out this cycle
   always_comb begin
      elig    = bus.req & ~gnt_q;
      ptr_eff = (ptr_q == ID_W'(3)) ? ID_W'(0) : ptr_q;
      ord0    = ptr_eff;
      ord1    = inc3(ord0);
      ord2    = inc3(ord1);
      found   = 1'b1;
      win     = ord0;
      if (elig[ord0])      win = ord0;
      else if (elig[ord1]) win = ord1;
      else if (elig[ord2]) win = ord2;
      else                 found = 1'b0;
   end

   // Command register and read-tag pipeline next state
   always_comb begin
      gnt_d       = '0;
      ptr_d       = ptr_eff;
      ram_en_d    = found;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cmd_id_d    = cmd_id_q;
      tag_vld_d   = tag_vld_q;
      tag_id_d    = tag_id_q;
      rvalid_d    = '0;
      rdata_d     = rdata_q;

      if (found) begin
         gnt_d       = NPORT'(NPORT'(1) << win);
         ptr_d       = inc3(win);
         ram_we_d    = bus.we[win];
         ram_addr_d  = bus.addr[win*ADDR_W +: ADDR_W];
         ram_wdata_d = bus.wdata[win*DATA_W +: DATA_W];
         cmd_id_d    = win;
      end

      tag_vld_d[0] = ram_en_q & ~ram_we_q;
      tag_id_d[0]  = cmd_id_q;
      for (int i = 1; i < int'(READ_LAT); i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      // Final stage: capture RAM data alongside the issuing port's pulse
      if (tag_vld_q[READ_LAT-1]) begin
         rvalid_d = NPORT'(NPORT'(1) << tag_id_q[READ_LAT-1]);
         rdata_d  = bus.ram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q       <= '0;
         ptr_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cmd_id_q    <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
      end else begin
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cmd_id_q    <= cmd_id_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-requester, round-robin arbiter that shares the single-port synchronous program/data RAM between instruction fetch (port 0), data load/store (port 1) and the debug/loader port (port 2). It registers one RAM command per cycle, tracks in-flight reads through a READ_LAT-deep tag pipeline, and routes each read result back to the requester that issued it. It sits between the control unit's memory-request outputs and the RAM macro.

## Interface

- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- READ_LAT, 1, RAM read latency in cycles from command edge to ram_rdata valid; legal range 1..4
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  3  per-port access request, bit i = port i
- we  input  3  per-port write enable, sampled with req
- addr  input  3*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  input  3*DATA_W  packed write data, port i at [i*DATA_W +: DATA_W]
- gnt  output  3  one-cycle grant pulse, one-hot or zero
- rvalid  output  3  one-cycle read-data-valid pulse, one-hot or zero
- rdata  output  DATA_W  read data, meaningful only when rvalid != 0
- ram_en  output  1  RAM command strobe
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data

## Operation

- Eligible set each cycle: req[i] & ~gnt[i] (a port is never re-granted in the cycle its grant is showing).
- Round-robin pointer ptr (2 bits, values 0..2). Priority order ptr, ptr+1, ptr+2 (mod 3). After granting port k, ptr <= (k+1) mod 3; unchanged when nothing granted.
- Winner k latched at the clock edge: gnt[k]=1, ram_en=1, ram_we=we[k], ram_addr/ram_wdata = port k values, all registered, valid for exactly one cycle.
- No eligible port: gnt=0, ram_en=0, ram_we=0; ram_addr/ram_wdata hold last value.
- Requester rule: hold req, we, addr, wdata stable from assertion through the gnt cycle; deassert or present a new request in the cycle after gnt. Back-to-back from one port: at most one grant every 2 cycles.
- Read tag pipeline: READ_LAT+1 stages of {valid, port id}. Stage 0 loaded with {ram_en & ~ram_we, k} at command edge. At the last stage rdata <= ram_rdata and rvalid[id] <= valid, both registered.
- Writes produce no rvalid; completion is the gnt pulse.
- Reads and writes interleave freely; pipeline accepts one new read per cycle, no stalls, no reordering (results return in issue order).
- Read-after-write to same address in consecutive commands returns the new data (RAM write-first behaviour is the RAM's responsibility; arbiter preserves command order).

## Timing

- Reset (rst=1 at edge): gnt=0, rvalid=0, rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, ptr=0, all tag-pipeline valids=0. In-flight reads are discarded: no rvalid appears after reset for commands issued before it.
- Requests present in the reset cycle are ignored; first grant possible at the edge after rst falls.
- Latency: req sampled at edge N -> gnt/ram_en high during cycle N+1 -> rvalid/rdata during cycle N+2+READ_LAT (READ_LAT=1: 3 cycles after sampling edge).
- Simultaneous: all three requesting with ptr=0 -> grants 0,1,2 in consecutive cycles, then 0 again once re-eligible.
- Lone requester sustained: grants every second cycle; ptr advances regardless of other ports.
- ptr never holds 3; if reached, treat as 0.
- rvalid and gnt may be high in the same cycle for the same or different ports.

## Test plan

- Reset: drive req=3'b111 with rst=1 for 3 cycles -> gnt=0, ram_en=0, all outputs 0; first gnt[0] one cycle after rst falls.
- Contention: req=3'b111, all reads, addr 0x10/0x20/0x30, RAM preloaded 0xA0A0/0xB0B0/0xC0C0 -> gnt order 0,1,2; rvalid order 0,1,2 with rdata 0xA0A0, 0xB0B0, 0xC0C0, each READ_LAT+1 cycles after its gnt.
- Write then read: port 1 writes 0x1234 to 0x05, then port 0 reads 0x05 -> ram_we=1 one cycle, no rvalid for write; rvalid[0] with rdata 0x1234.
- Fairness: port 0 held requesting continuously, port 2 asserts once -> port 2 granted within 2 cycles; port 0 never granted in consecutive cycles.
- Reset mid-read: port 2 read granted, rst asserted the next cycle -> no rvalid[2] ever appears; ptr=0 afterwards.
- READ_LAT=3 build: back-to-back reads from ports 0 and 1 -> rvalid pulses 4 cycles after respective gnt, correct data and port, no overlap loss.
